// File: rtl/iohub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iohub_pkg
// Brief   : Shared constants for the iohub UART transmit scheduler.
// Revision: 1.0  initial release
// ============================================================================
package iohub_pkg;

    localparam int unsigned c_BYTE_W    = 8;
    localparam int unsigned c_ACK_GUARD = 2;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_LOAD1      = 3'd1;
    localparam logic [2:0] c_ST_WAIT1_ACK  = 3'd2;
    localparam logic [2:0] c_ST_WAIT1_DONE = 3'd3;
    localparam logic [2:0] c_ST_LOAD2      = 3'd4;
    localparam logic [2:0] c_ST_WAIT2_ACK  = 3'd5;
    localparam logic [2:0] c_ST_WAIT2_DONE = 3'd6;

endpackage
`default_nettype wire

// File: rtl/iohub_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : iohub_rr_arb2
// Brief   : Two-way round-robin arbiter; combinational grant, registered
//           last-winner pointer advanced on i_update.
// Revision: 1.0  initial release
// ============================================================================
module iohub_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    output logic o_gnt0,
    output logic o_gnt1,
    output logic o_any
);

    // r_last = 1 means requester 1 won most recently, so requester 0 is favoured
    logic r_last;
    logic w_gnt0;
    logic w_gnt1;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
        end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_update && (w_gnt0 || w_gnt1)) begin
            r_last <= w_gnt1;
        end
    end

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;
    assign o_any  = i_req0 | i_req1;

endmodule
`default_nettype wire

// File: rtl/iohub_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : iohub_tx_sched
// Brief   : Arbitrates two 16-bit word requesters and sequences each granted
//           word as two bytes onto a start/busy UART transmitter.
// Revision: 1.0  initial release
// ============================================================================
module iohub_tx_sched
    import iohub_pkg::*;
#(
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_i,
    input  logic [15:0]         dat0_i,
    output logic                ack0_o,
    input  logic                req1_i,
    input  logic [15:0]         dat1_i,
    output logic                ack1_o,
    input  logic                tx_busy_i,
    output logic                tx_start_o,
    output logic [c_BYTE_W-1:0] tx_byte_o,
    output logic                idle_o,
    output logic [CNT_W-1:0]    words_sent_o
);

    logic [2:0]          r_state;
    logic [15:0]         r_word;
    logic [1:0]          r_guard;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_tx_start;
    logic [c_BYTE_W-1:0] r_tx_byte;
    logic                r_idle;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_any;
    logic                w_update;
    logic [c_BYTE_W-1:0] w_byte_first;
    logic [c_BYTE_W-1:0] w_byte_second;

    assign w_update      = (r_state == c_ST_IDLE);
    assign w_byte_first  = MSB_FIRST ? r_word[15:8] : r_word[7:0];
    assign w_byte_second = MSB_FIRST ? r_word[7:0]  : r_word[15:8];

    iohub_rr_arb2 u_arb (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_req0   (req0_i),
        .i_req1   (req1_i),
        .i_update (w_update),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1),
        .o_any    (w_any)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_word     <= 16'h0000;
            r_guard    <= 2'd0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
            r_idle     <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_word  <= w_gnt1 ? dat1_i : dat0_i;
                        r_ack0  <= w_gnt0;
                        r_ack1  <= w_gnt1;
                        r_idle  <= 1'b0;
                        r_state <= c_ST_LOAD1;
                    end
                end
                c_ST_LOAD1: begin
                    if (!tx_busy_i) begin
                        r_tx_byte  <= w_byte_first;
                        r_tx_start <= 1'b1;
                        r_guard    <= 2'd0;
                        r_state    <= c_ST_WAIT1_ACK;
                    end
                end
                // A UART that finishes very fast may never show busy; the guard
                // bounds the wait so the FSM cannot stall here.
                c_ST_WAIT1_ACK: begin
                    if (tx_busy_i || (r_guard == 2'(c_ACK_GUARD - 1))) begin
                        r_state <= c_ST_WAIT1_DONE;
                    end else begin
                        r_guard <= r_guard + 2'd1;
                    end
                end
                c_ST_WAIT1_DONE: begin
                    if (!tx_busy_i) begin
                        r_state <= c_ST_LOAD2;
                    end
                end
                c_ST_LOAD2: begin
                    if (!tx_busy_i) begin
                        r_tx_byte  <= w_byte_second;
                        r_tx_start <= 1'b1;
                        r_guard    <= 2'd0;
                        r_state    <= c_ST_WAIT2_ACK;
                    end
                end
                c_ST_WAIT2_ACK: begin
                    if (tx_busy_i || (r_guard == 2'(c_ACK_GUARD - 1))) begin
                        r_state <= c_ST_WAIT2_DONE;
                    end else begin
                        r_guard <= r_guard + 2'd1;
                    end
                end
                c_ST_WAIT2_DONE: begin
                    if (!tx_busy_i) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_idle  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_idle  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ack0_o       = r_ack0;
    assign ack1_o       = r_ack1;
    assign tx_start_o   = r_tx_start;
    assign tx_byte_o    = r_tx_byte;
    assign idle_o       = r_idle;
    assign words_sent_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iohub_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_iohub_tx_sched
// Brief   : Self-checking bench for iohub_tx_sched with a transaction model.
// Revision: 1.0  initial release
// ============================================================================
module tb_iohub_tx_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req0, req1, busy;
    logic [15:0] dat0, dat1;
    logic        ack0, ack1, tx_start, idle;
    logic [7:0]  tx_byte;
    logic [15:0] words;

    logic        q_req;
    logic [15:0] q_dat;
    logic        l_ack0, l_ack1, l_start, l_idle;
    logic [7:0]  l_byte;
    logic [15:0] l_words;
    logic        c_ack0, c_ack1, c_start, c_idle;
    logic [7:0]  c_byte;
    logic [1:0]  c_words;

    iohub_tx_sched u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .dat0_i(dat0), .ack0_o(ack0),
        .req1_i(req1), .dat1_i(dat1), .ack1_o(ack1),
        .tx_busy_i(busy), .tx_start_o(tx_start), .tx_byte_o(tx_byte),
        .idle_o(idle), .words_sent_o(words)
    );

    iohub_tx_sched #(.MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_i(rst),
        .req0_i(q_req), .dat0_i(q_dat), .ack0_o(l_ack0),
        .req1_i(1'b0), .dat1_i(16'h0000), .ack1_o(l_ack1),
        .tx_busy_i(1'b0), .tx_start_o(l_start), .tx_byte_o(l_byte),
        .idle_o(l_idle), .words_sent_o(l_words)
    );

    iohub_tx_sched #(.CNT_W(2)) u_cnt2 (
        .clk_i(clk), .rst_i(rst),
        .req0_i(q_req), .dat0_i(q_dat), .ack0_o(c_ack0),
        .req1_i(1'b0), .dat1_i(16'h0000), .ack1_o(c_ack1),
        .tx_busy_i(1'b0), .tx_start_o(c_start), .tx_byte_o(c_byte),
        .idle_o(c_idle), .words_sent_o(c_words)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART model: busy rises one cycle after a start and lasts 10 cycles
    bit uart_normal = 1'b1;
    bit force_busy  = 1'b0;
    int busy_cnt    = 0;
    bit dly         = 1'b0;
    always @(posedge clk) begin
        #2;
        if (busy_cnt > 0) busy_cnt--;
        if (dly) begin
            dly = 1'b0;
            if (uart_normal) busy_cnt = 10;
        end
        if (tx_start === 1'b1) dly = 1'b1;
        busy = force_busy || (busy_cnt > 0);
    end

    // Transaction model: grant rule, byte order, word count
    logic [7:0]  mq[$];
    logic [7:0]  blog[$];
    bit          alog[$];
    logic [7:0]  llog[$];
    bit          m_last = 1'b1;
    logic [15:0] m_words = '0;
    logic [7:0]  m_byte = '0;
    int          n_start = 0, n_ack0 = 0, n_ack1 = 0;
    logic        p_rst = 1'b1, p_idle = 1'b0, p_req0 = 1'b0, p_req1 = 1'b0;
    logic [15:0] p_dat0 = '0, p_dat1 = '0;

    always @(negedge clk) begin
        bit          e_a0, e_a1, g1;
        logic [15:0] w;
        logic [7:0]  eb;
        if (p_rst) begin
            mq.delete();
            m_last  = 1'b1;
            m_words = '0;
            m_byte  = '0;
            chk("reset_outputs", {ack0, ack1, tx_start, tx_byte, idle, words},
                {3'b000, 8'h00, 1'b1, 16'h0000});
        end else begin
            e_a0 = 1'b0;
            e_a1 = 1'b0;
            if (p_idle && (p_req0 || p_req1)) begin
                g1   = p_req1 && (!p_req0 || !m_last);
                e_a0 = !g1;
                e_a1 = g1;
                w    = g1 ? p_dat1 : p_dat0;
                mq.push_back(w[15:8]);
                mq.push_back(w[7:0]);
                m_last = g1;
            end
            chk("ack_pair", {ack0, ack1}, {e_a0, e_a1});
            if (ack0 === 1'b1) begin n_ack0++; alog.push_back(1'b0); end
            if (ack1 === 1'b1) begin n_ack1++; alog.push_back(1'b1); end
            if (tx_start === 1'b1) begin
                n_start++;
                blog.push_back(tx_byte);
                if (mq.size() == 0) begin
                    chk("extra_tx_start", 1, 0);
                end else begin
                    eb = mq.pop_front();
                    chk("tx_byte", tx_byte, eb);
                    m_byte = eb;
                    if (mq.size() % 2 == 0) m_words = m_words + 16'd1;
                end
            end else begin
                chk("tx_byte_hold", tx_byte, m_byte);
            end
            if (idle === 1'b1) chk("words_sent", words, m_words);
            if (mq.size() != 0) chk("idle_while_pending", idle, 0);
        end
        if (l_start === 1'b1) llog.push_back(l_byte);
        p_rst  = rst;
        p_idle = idle;
        p_req0 = req0;
        p_req1 = req1;
        p_dat0 = dat0;
        p_dat1 = dat1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ack0 || ack1) got++;
            if (got == n) return;
        end
        chk("ack_timeout", got, n);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (idle) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_bytes(input string name, input int base, input logic [7:0] b0, input logic [7:0] b1);
        if (blog.size() >= base + 2) begin
            chk({name, "_byte0"}, blog[base], b0);
            chk({name, "_byte1"}, blog[base+1], b1);
        end else begin
            chk({name, "_nbytes"}, blog.size() - base, 2);
        end
    endtask

    initial begin
        int          base, abase, na, ns, n;
        logic [7:0]  exp_c [8];
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; dat0 = '0; dat1 = '0;
        busy = 1'b0; q_req = 1'b0; q_dat = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_literal", {idle, words, ack0, ack1, tx_start, tx_byte},
            {1'b1, 16'h0000, 3'b000, 8'h00});

        // Contention: requester 0 wins first out of reset, then alternation
        base = blog.size(); abase = alog.size();
        dat0 = 16'h1111; dat1 = 16'h2222; req0 = 1'b1; req1 = 1'b1;
        wait_acks(4, 600);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(200);
        exp_c = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11, 8'h11, 8'h22, 8'h22};
        if (blog.size() >= base + 8 && alog.size() >= abase + 4) begin
            for (int i = 0; i < 8; i++) chk("contention_byte", blog[base+i], exp_c[i]);
            chk("grant_order", {alog[abase], alog[abase+1], alog[abase+2], alog[abase+3]}, 4'b0101);
        end else begin
            chk("contention_count", blog.size() - base, 8);
        end
        chk("contention_words", words, 4);

        // Single word
        base = blog.size(); na = n_ack0; ns = n_start;
        dat0 = 16'hA55A; req0 = 1'b1;
        wait_acks(1, 50);
        req0 = 1'b0;
        wait_idle(200);
        chk_bytes("single", base, 8'hA5, 8'h5A);
        chk("single_acks", n_ack0 - na, 1);
        chk("single_starts", n_start - ns, 2);
        chk("single_words", words, 5);
        chk("single_idle", idle, 1);

        // UART busy at grant: no start until busy falls
        base = blog.size(); ns = n_start;
        dat1 = 16'h0F0F; req1 = 1'b1;
        wait_acks(1, 50);
        force_busy = 1'b1; req1 = 1'b0;
        repeat (20) tick();
        chk("busy_hold_starts", n_start - ns, 0);
        force_busy = 1'b0;
        for (int i = 0; i < 10 && (n_start - ns) == 0; i++) tick();
        chk("busy_release_starts", n_start - ns, 1);
        wait_idle(200);
        chk("busy_total_starts", n_start - ns, 2);
        chk_bytes("busy", base, 8'h0F, 8'h0F);

        // Missing busy: the guard alone must move each byte along
        uart_normal = 1'b0;
        base = blog.size(); ns = n_start; n = 0;
        dat0 = 16'hC3C3; req0 = 1'b1;
        tick(); n++;
        req0 = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin tick(); n++; end
        chk("noguard_word_le10", (n <= 10), 1);
        chk("noguard_starts", n_start - ns, 2);
        chk("noguard_words", words, 7);
        chk_bytes("noguard", base, 8'hC3, 8'hC3);
        uart_normal = 1'b1;

        // Reset while waiting for the first byte to drain
        ns = n_start; na = n_ack0;
        dat0 = 16'hCAFE; req0 = 1'b1;
        wait_acks(1, 50);
        req0 = 1'b0;
        for (int i = 0; i < 10 && (n_start - ns) == 0; i++) tick();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_literal", {idle, words, ack0, ack1, tx_start, tx_byte},
            {1'b1, 16'h0000, 3'b000, 8'h00});
        repeat (5) tick();
        chk("midreset_no_reack", n_ack0 - na, 1);
        base = blog.size();
        dat1 = 16'hBEEF; req1 = 1'b1;
        wait_acks(1, 50);
        req1 = 1'b0;
        wait_idle(200);
        chk_bytes("after_reset", base, 8'hBE, 8'hEF);
        chk("after_reset_words", words, 1);

        // Parameter variants: LSB-first order and a 2-bit wrapping counter
        q_dat = 16'h1234; q_req = 1'b1; na = 0;
        for (int i = 0; i < 300 && na < 5; i++) begin
            tick();
            if (c_ack0) na++;
        end
        q_req = 1'b0;
        chk("param_acks", na, 5);
        for (int i = 0; i < 50 && !c_idle; i++) tick();
        tick();
        if (llog.size() >= 2) begin
            chk("lsb_byte0", llog[0], 8'h34);
            chk("lsb_byte1", llog[1], 8'h12);
        end else begin
            chk("lsb_nbytes", llog.size(), 2);
        end
        chk("lsb_words", l_words, 5);
        chk("cnt2_wrap", c_words, 1);

        chk("model_drained", mq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
